// File: rtl/hazard_stall_ctrl.sv
// D-stage hazard detection: Tuse/Tnew register stalls plus a multiply/divide busy interlock.
// Tracks destination/Tnew of the E and M instructions and drives PC/D hold and the E bubble.
module hazard_src_chk (
  input  logic [4:0] src,
  input  logic [1:0] tuse,
  input  logic [4:0] a3e,
  input  logic [1:0] tnewe,
  input  logic [4:0] a3m,
  input  logic [1:0] tnewm,
  output logic       hit
);
  // $zero is never a real dependency, even when a bubble carries A3=0 downstream.
  assign hit = (src != 5'd0) &
               (((src == a3e) & (tuse < tnewe)) | ((src == a3m) & (tuse < tnewm)));
endmodule

module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [1:0] TuseRs,
  input  logic [1:0] TuseRt,
  input  logic [4:0] A3D,
  input  logic [1:0] TnewD,
  input  logic       mdUseD,
  input  logic       mduStart,
  input  logic       mduIsDiv,
  output logic       stall,
  output logic       enPC,
  output logic       enD,
  output logic       FlushE,
  output logic       mduBusy
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [4:0]       A3E, A3M;
  logic [1:0]       TnewE, TnewM;
  logic [CW-1:0]    mduCnt;
  logic [1:0][4:0]  src;
  logic [1:0][1:0]  tuse;
  logic [1:0]       hit;
  logic             stallMd;

  assign src  = {rtD, rsD};
  assign tuse = {TuseRt, TuseRs};

  generate
    for (genvar g = 0; g < 2; g++) begin : g_src
      hazard_src_chk u_chk (
        .src   (src[g]),
        .tuse  (tuse[g]),
        .a3e   (A3E),
        .tnewe (TnewE),
        .a3m   (A3M),
        .tnewm (TnewM),
        .hit   (hit[g])
      );
    end
  endgenerate

  assign mduBusy = (mduCnt != '0);
  // The start cycle itself blocks, so a dependent mfhi/mflo cannot slip in behind it.
  assign stallMd = mdUseD & (mduBusy | mduStart);
  assign stall   = hit[0] | hit[1] | stallMd;
  assign enPC    = ~stall;
  assign enD     = ~stall;
  assign FlushE  = stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      A3E   <= '0;
      TnewE <= '0;
      A3M   <= '0;
      TnewM <= '0;
    end else begin
      // A stalled D instruction leaves a bubble in E rather than its own destination.
      A3E   <= stall ? 5'd0 : A3D;
      TnewE <= stall ? 2'd0 : TnewD;
      A3M   <= A3E;
      TnewM <= (TnewE == 2'd0) ? 2'd0 : TnewE - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      mduCnt <= '0;
    else if (mduStart && !mduBusy)
      mduCnt <= mduIsDiv ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    else if (mduBusy)
      mduCnt <= mduCnt - 1'b1;
  end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: vector table for register hazards, hand sequences for MDU/reset.
module tb_hazard_stall_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rsD, rtD, A3D;
  logic [1:0] TuseRs, TuseRt, TnewD;
  logic       mdUseD, mduStart, mduIsDiv;
  logic       stall, enPC, enD, FlushE, mduBusy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [4:0] rs;  logic [1:0] tus;
    logic [4:0] rt;  logic [1:0] tut;
    logic [4:0] a3;  logic [1:0] tn;
    logic md, st, dv;
    logic es, eb;
  } vec_t;

  typedef struct packed { logic s; logic b; } exp_t;
  exp_t sbq[$];

  hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .rsD(rsD), .rtD(rtD), .TuseRs(TuseRs), .TuseRt(TuseRt),
    .A3D(A3D), .TnewD(TnewD), .mdUseD(mdUseD), .mduStart(mduStart), .mduIsDiv(mduIsDiv),
    .stall(stall), .enPC(enPC), .enD(enD), .FlushE(FlushE), .mduBusy(mduBusy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [4:0] rs, input logic [1:0] tus,
                              input logic [4:0] rt, input logic [1:0] tut,
                              input logic [4:0] a3, input logic [1:0] tn,
                              input logic md, input logic es);
    vec_t v;
    v.rs = rs; v.tus = tus; v.rt = rt; v.tut = tut; v.a3 = a3; v.tn = tn;
    v.md = md; v.st = 1'b0; v.dv = 1'b0; v.es = es; v.eb = 1'b0;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    exp_t e;
    rsD = v.rs; TuseRs = v.tus; rtD = v.rt; TuseRt = v.tut;
    A3D = v.a3; TnewD = v.tn; mdUseD = v.md; mduStart = v.st; mduIsDiv = v.dv;
    e.s = v.es; e.b = v.eb;
    sbq.push_back(e);
  endtask

  task automatic sample_now(input string name);
    exp_t e;
    logic [4:0] act, req;
    tests++;
    if (sbq.size() == 0) begin
      fails++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sbq.pop_front();
    act = {stall, enPC, enD, FlushE, mduBusy};
    req = {e.s, ~e.s, ~e.s, e.s, e.b};
    if (act !== req) begin
      fails++;
      $display("FAIL %s: {stall,enPC,enD,FlushE,mduBusy} got %b want %b", name, act, req);
    end
  endtask

  // Inputs change just after the rising edge; outputs are checked on the falling edge.
  task automatic apply(input vec_t v, input string name);
    drive(v);
    @(negedge clk);
    sample_now(name);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[21];
  vec_t v, idle;

  initial begin
    idle = mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0);
    //             rs  tus   rt  tut  a3  tn  md  exp_stall
    tbl[0]  = mk( 0, 3,  0, 3,  8, 2, 0, 0);  // load-use producer enters E
    tbl[1]  = mk( 8, 0,  0, 3,  0, 0, 0, 1);  // hazard vs E, TnewE=2
    tbl[2]  = mk( 8, 0,  0, 3,  0, 0, 0, 1);  // hazard vs M, TnewM=1
    tbl[3]  = mk( 8, 0,  0, 3,  0, 0, 0, 0);
    tbl[4]  = mk( 0, 3,  0, 3,  8, 1, 0, 0);  // forwardable producer
    tbl[5]  = mk( 8, 1,  0, 3,  0, 0, 0, 0);
    tbl[6]  = mk( 8, 1,  0, 3,  0, 0, 0, 0);
    tbl[7]  = mk( 0, 3,  0, 3,  0, 2, 0, 0);  // writer of $zero
    tbl[8]  = mk( 0, 3,  0, 0,  0, 0, 0, 0);
    tbl[9]  = mk( 0, 3,  0, 0,  0, 0, 0, 0);
    tbl[10] = mk( 0, 3,  0, 3,  5, 0, 0, 0);  // TnewE=0 must not wrap in M
    tbl[11] = mk( 0, 3,  5, 0,  0, 0, 0, 0);
    tbl[12] = mk( 0, 3,  5, 0,  0, 0, 0, 0);
    tbl[13] = mk( 0, 3,  0, 3,  9, 2, 0, 0);  // rt hazard, TuseRt=1
    tbl[14] = mk( 0, 3,  9, 1,  0, 0, 0, 1);
    tbl[15] = mk( 0, 3,  9, 1,  0, 0, 0, 0);
    tbl[16] = mk( 0, 3,  0, 3,  3, 2, 0, 0);  // stalled D must bubble E
    tbl[17] = mk( 3, 0,  0, 3,  7, 2, 0, 1);
    tbl[18] = mk( 3, 0,  0, 3,  7, 2, 0, 1);
    tbl[19] = mk( 7, 0,  0, 3,  0, 0, 0, 0);
    tbl[20] = mk( 0, 3,  0, 3,  0, 0, 1, 0);  // mdUseD with idle MDU

    reset = 1'b1;
    drive(idle);
    sbq.delete();
    repeat (2) @(posedge clk);
    #1;
    drive(idle);
    @(negedge clk);
    sample_now("reset_state");
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 21; i++)
      apply(tbl[i], $sformatf("vec%0d", i));

    // Divide: busy for exactly 10 cycles after the start edge, mdUseD blocks throughout.
    v = idle; v.md = 1'b1; v.st = 1'b1; v.dv = 1'b1; v.es = 1'b1; v.eb = 1'b0;
    apply(v, "div_start");
    for (int i = 1; i <= 11; i++) begin
      v = idle; v.md = 1'b1;
      v.es = (i <= 10); v.eb = (i <= 10);
      apply(v, $sformatf("div_t%0d", i));
    end

    // Multiply, with a divide start 2 cycles later that must be ignored.
    v = idle; v.st = 1'b1;
    apply(v, "mul_start");
    for (int i = 1; i <= 6; i++) begin
      v = idle;
      if (i == 2) begin v.st = 1'b1; v.dv = 1'b1; end
      v.eb = (i <= 5);
      apply(v, $sformatf("mul_t%0d", i));
    end

    // Reset asserted mid-cycle during divide busy cycle 4.
    v = idle; v.a3 = 5'd8; v.tn = 2'd2; v.st = 1'b1; v.dv = 1'b1;
    apply(v, "rdiv_start");
    for (int i = 1; i <= 3; i++) begin
      v = idle; v.a3 = 5'd8; v.tn = 2'd2; v.eb = 1'b1;
      apply(v, $sformatf("rdiv_t%0d", i));
    end
    v = idle; v.rs = 5'd8; v.tus = 2'd0; v.es = 1'b1; v.eb = 1'b1;
    drive(v);
    #1;
    sample_now("rdiv_t4_pre");
    #1;
    reset = 1'b1;
    v.es = 1'b0; v.eb = 1'b0;
    drive(v);
    #1;
    sample_now("rst_async");
    drive(v);
    @(negedge clk);
    sample_now("rst_hold");
    @(posedge clk);
    #1;
    drive(v);
    @(negedge clk);
    sample_now("rst_hold2");
    reset = 1'b0;
    @(posedge clk);
    #1;
    v = idle; v.rs = 5'd8; v.tus = 2'd0; v.md = 1'b1;
    apply(v, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, meaning the number of busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning the number of busy cycles for div/divu.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port rsD, input, 5, the rs register number of the D-stage instruction.
REQ-006 SHALL have port rtD, input, 5, the rt register number of the D-stage instruction.
REQ-007 SHALL have port TuseRs, input, 2, the stage distance before the D-stage instruction needs rs (3 = never used).
REQ-008 SHALL have port TuseRt, input, 2, the stage distance before the D-stage instruction needs rt (3 = never used).
REQ-009 SHALL have port A3D, input, 5, the destination register of the D-stage instruction (0 = none).
REQ-010 SHALL have port TnewD, input, 2, the cycles after entering E before the D-stage result is forwardable.
REQ-011 SHALL have port mdUseD, input, 1, meaning the D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-012 SHALL have port mduStart, input, 1, meaning the E-stage instruction is mult/multu/div/divu.
REQ-013 SHALL have port mduIsDiv, input, 1, which qualifies mduStart (1 = div class).
REQ-014 SHALL have port stall, output, 1, meaning the D-stage instruction must hold.
REQ-015 SHALL have port enPC, output, 1, the PC write enable.
REQ-016 SHALL have port enD, output, 1, the enable to the D pipeline register.
REQ-017 SHALL have port FlushE, output, 1, which inserts a bubble into the E pipeline register.
REQ-018 SHALL have port mduBusy, output, 1, meaning the multiply/divide unit is occupied.

Function
REQ-019 SHALL keep shadow registers A3E[4:0], TnewE[1:0], A3M[4:0], TnewM[1:0], which track the instructions in E and M.
REQ-020 SHALL update the shadow registers on each clock edge: if stall=1, A3E<=0 and TnewE<=0; otherwise A3E<=A3D and TnewE<=TnewD.
REQ-021 SHALL load A3M<=A3E and TnewM<=max(TnewE-1,0) on each clock edge, with no underflow wrap.
REQ-022 SHALL compute stallRs = (rsD!=0) & ((rsD==A3E & TuseRs<TnewE) | (rsD==A3M & TuseRs<TnewM)).
REQ-023 SHALL compute stallRt with the same formula using rtD and TuseRt.
REQ-024 SHALL never stall on register 0, including when A3E or A3M equals 0.
REQ-025 SHALL keep a down-counter mduCnt, wide enough for max(MULT_CYCLES,DIV_CYCLES), and SHALL drive mduBusy = (mduCnt!=0).
REQ-026 SHALL load mduCnt with DIV_CYCLES (if mduIsDiv) or MULT_CYCLES on an edge where mduStart=1 and mduBusy=0.
REQ-027 SHALL otherwise decrement mduCnt by 1 while it is nonzero, so mduBusy stays high for exactly N cycles after the start edge.
REQ-028 SHALL ignore mduStart while mduBusy=1, with no reload and no extension of the busy period.
REQ-029 SHALL compute stallMd = mdUseD & (mduBusy | mduStart), so the start cycle itself also blocks.
REQ-030 SHALL make stall = stallRs | stallRt | stallMd combinationally, within the same cycle as its inputs.
REQ-031 SHALL drive enPC = enD = ~stall and FlushE = stall.
REQ-032 SHALL give stallMd no priority over or under the register hazards; the conditions are a plain OR.

Reset
REQ-033 SHALL asynchronously clear A3E, TnewE, A3M, TnewM and mduCnt to 0 while reset=1, regardless of clk.
REQ-034 SHALL hold outputs stall=0, enPC=1, enD=1, FlushE=0 and mduBusy=0 during reset, given mdUseD=0.
REQ-035 SHALL abort an in-progress MDU count on reset mid-operation; mduBusy SHALL be 0 on the first cycle after reset is released.

Verification
REQ-036 SHALL verify the load-use case: A3D=8, TnewD=2 clocked in, then rsD=8, TuseRs=0 -> stall=1 for 2 cycles (TnewE=2, then TnewM=1), then stall=0.
REQ-037 SHALL verify the forwardable case: A3D=8, TnewD=1 clocked in, then rsD=8, TuseRs=1 -> stall=0 throughout.
REQ-038 SHALL verify the zero-register case: A3D=0, TnewD=2, then rtD=0, TuseRt=0 -> stall=0.
REQ-039 SHALL verify div busy: mduStart=1, mduIsDiv=1 at edge t -> mduBusy=1 for cycles t+1..t+10, 0 at t+11; with mdUseD=1 held, stall=1 in the start cycle and through t+10.
REQ-040 SHALL verify start-while-busy: mult start, then a second mduStart 2 cycles later -> mduBusy still drops after exactly 5 cycles from the first start.
REQ-041 SHALL verify reset mid-div: reset pulsed at busy cycle 4 -> mduBusy=0 and all shadows 0 immediately, without waiting for a clock edge.
